// File: rtl/vram_line_fetch_if.sv
// Port-B read side of the text VRAM: line requests, front-buffer
// lookup, fetch status and the BSRAM read bus.
interface vram_line_fetch_if #(
  parameter int ADDR_W = 13
);
  logic              line_req;
  logic [5:0]        text_row;
  logic              swap;
  logic [5:0]        rd_col;
  logic [7:0]        rd_char;
  logic              busy;
  logic              line_done;
  logic              overrun;
  logic              ceb;
  logic              oce;
  logic [ADDR_W-1:0] adb;
  logic [7:0]        dout;

  modport master (
    output line_req, text_row, swap, rd_col, dout,
    input  rd_char, busy, line_done, overrun, ceb, oce, adb
  );

  modport slave (
    input  line_req, text_row, swap, rd_col, dout,
    output rd_char, busy, line_done, overrun, ceb, oce, adb
  );
endinterface

// File: rtl/vram_line_fetch.sv
// Streams one text row out of BSRAM port B into a ping-pong line
// buffer; the glyph renderer reads the front half by column.
module vram_line_fetch #(
  parameter int                COLS         = 60,
  parameter int                ROWS         = 34,
  parameter int                ADDR_W       = 13,
  parameter logic [ADDR_W-1:0] VRAM_BASE    = 13'h0200,
  parameter int                READ_LATENCY = 2
) (
  input logic              clk,
  input logic              rst,
  vram_line_fetch_if.slave bus
);

  localparam int AW = ADDR_W + 6;
  localparam int RL = READ_LATENCY;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_front;
  logic              r_tgt;
  logic              r_oor;
  logic              r_busy;
  logic              r_done;
  logic              r_ovr;
  logic              r_ceb;
  logic [ADDR_W-1:0] r_adb;
  logic [5:0]        r_col;
  logic [RL-1:0]     r_pv;
  logic [5:0]        r_pc [RL];
  logic [7:0]        r_rd;
  logic [7:0]        r_buf [128];

  logic [AW-1:0]     w_base;
  logic              w_oor;
  logic              w_last;
  logic              w_rd_oob;

  assign w_base   = AW'(VRAM_BASE)
                  + AW'(bus.text_row) * AW'(COLS);
  assign w_oor    = {1'b0, bus.text_row} >= 7'(ROWS);
  assign w_last   = r_col == 6'(COLS - 1);
  assign w_rd_oob = {1'b0, bus.rd_col} >= 7'(COLS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_front <= 1'b0;
      r_tgt   <= 1'b0;
      r_oor   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
      r_ceb   <= 1'b0;
      r_adb   <= '0;
      r_col   <= '0;
      r_pv    <= '0;
      r_rd    <= 8'h00;
      for (int i = 0; i < RL; i++) begin
        r_pc[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      if (bus.swap) begin
        r_front <= ~r_front;
      end
      if (bus.line_req && r_state != S_IDLE) begin
        r_ovr <= 1'b1;
      end
      r_rd <= w_rd_oob ? 8'h00
            : r_buf[{r_front, bus.rd_col}];
      // Column tags ride alongside the BSRAM read latency
      r_pv[0] <= r_state == S_ISSUE;
      r_pc[0] <= r_col;
      for (int i = 1; i < RL; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pc[i] <= r_pc[i-1];
      end
      unique case (r_state)
        S_IDLE: begin
          if (bus.line_req) begin
            r_tgt   <= ~r_front;
            r_oor   <= w_oor;
            r_adb   <= w_base[ADDR_W-1:0];
            r_ceb   <= ~w_oor;
            r_col   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_col <= r_col + 6'd1;
          r_adb <= r_adb + 1'b1;
          if (w_last) begin
            r_ceb   <= 1'b0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_pv == '0) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Out-of-range rows fill the target with blanks on normal timing
  always_ff @(posedge clk) begin
    if (!rst && r_pv[RL-1]) begin
      r_buf[{r_tgt, r_pc[RL-1]}] <= r_oor ? 8'h00 : bus.dout;
    end
  end

  assign bus.rd_char   = r_rd;
  assign bus.busy      = r_busy;
  assign bus.line_done = r_done;
  assign bus.overrun   = r_ovr;
  assign bus.ceb       = r_ceb;
  assign bus.oce       = r_busy;
  assign bus.adb       = r_adb;

endmodule

// File: tb/tb_vram_line_fetch.sv
// Directed bench for vram_line_fetch with behavioural SDPB port-B
// models (output register, two-cycle read latency).
module tb_vram_line_fetch;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [7:0] mem1 [0:8191];
  logic [7:0] mem2 [0:8191];
  logic [7:0] m1_q;
  logic [7:0] m2_q;

  vram_line_fetch_if #(.ADDR_W(13)) u_if ();
  vram_line_fetch_if #(.ADDR_W(13)) u_if2 ();

  vram_line_fetch u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  vram_line_fetch #(.VRAM_BASE(13'h1FF0)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (u_if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (u_if.ceb) m1_q <= mem1[u_if.adb];
    if (u_if.oce) u_if.dout <= m1_q;
    if (u_if2.ceb) m2_q <= mem2[u_if2.adb];
    if (u_if2.oce) u_if2.dout <= m2_q;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input  logic [5:0] row,
                       input  int         req2,
                       input  logic [7:0] rd_exp,
                       input  logic       chk_rd,
                       output int         n_ceb,
                       output int         done_i,
                       output logic       adb_ok,
                       output logic       rd_ok,
                       output logic       ovr_ok);
    logic [12:0] base;
    base = 13'(32'h200 + 32'(row) * 60);
    u_if.text_row = row;
    u_if.line_req = 1'b1;
    tick();
    u_if.line_req = 1'b0;
    n_ceb  = 0;
    done_i = -1;
    adb_ok = 1'b1;
    rd_ok  = 1'b1;
    ovr_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (u_if.ceb) begin
        if (u_if.adb !== base + 13'(n_ceb)) adb_ok = 1'b0;
        n_ceb++;
      end
      if (chk_rd && u_if.rd_char !== rd_exp) rd_ok = 1'b0;
      if (req2 >= 0) begin
        if (i < req2 && u_if.overrun !== 1'b0) ovr_ok = 1'b0;
        if (i >= req2 && u_if.overrun !== 1'b1) ovr_ok = 1'b0;
      end
      if (u_if.line_done) begin
        done_i = i;
        break;
      end
      u_if.line_req = (i == req2 - 1);
      tick();
    end
    u_if.line_req = 1'b0;
  endtask

  int          n_ceb;
  int          done_i;
  int          cnt;
  logic        adb_ok;
  logic        rd_ok;
  logic        ovr_ok;
  logic [12:0] exp_adb;

  initial begin
    checks   = 0;
    failures = 0;
    for (int a = 0; a < 8192; a++) begin
      mem1[a] = 8'hEE;
      mem2[a] = 8'hEE;
    end
    for (int k = 0; k < 60; k++) begin
      mem1[32'h200 + 120 + k] = 8'(k + 1);
      mem1[32'h200 + k]       = 8'(8'h40 + k);
      mem1[32'h200 + 60 + k]  = 8'(8'h80 + k);
      mem2[(32'h1FF0 + k) % 8192] = 8'(8'hA0 + k);
    end

    rst            = 1'b1;
    u_if.line_req  = 1'b0;
    u_if.text_row  = '0;
    u_if.swap      = 1'b0;
    u_if.rd_col    = 6'd63;
    u_if2.line_req = 1'b0;
    u_if2.text_row = '0;
    u_if2.swap     = 1'b0;
    u_if2.rd_col   = 6'd63;
    repeat (3) tick();
    chk("rst_busy", 32'(u_if.busy), 0);
    chk("rst_done", 32'(u_if.line_done), 0);
    chk("rst_ovr", 32'(u_if.overrun), 0);
    chk("rst_ceb", 32'(u_if.ceb), 0);
    chk("rst_adb", 32'(u_if.adb), 0);
    chk("rst_oce", 32'(u_if.oce), 0);
    chk("rst_rdchar", 32'(u_if.rd_char), 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (u_if.ceb || u_if.busy || u_if2.ceb) cnt++;
      tick();
    end
    chk("idle_activity", 32'(cnt), 0);

    fetch(6'd2, -1, 8'h00, 1'b0, n_ceb, done_i, adb_ok, rd_ok, ovr_ok);
    chk("row2_ceb_len", 32'(n_ceb), 60);
    chk("row2_adb_seq", 32'(adb_ok), 1);
    chk("row2_done_at", 32'(done_i), 63);
    chk("row2_busy_done", 32'(u_if.busy), 1);
    chk("row2_oce", 32'(u_if.oce), 1);
    u_if.swap = 1'b1;
    tick();
    u_if.swap = 1'b0;
    chk("row2_busy_after", 32'(u_if.busy), 0);
    chk("row2_done_pulse", 32'(u_if.line_done), 0);
    u_if.rd_col = 6'd5;
    tick();
    chk("row2_col5", 32'(u_if.rd_char), 32'h06);
    u_if.rd_col = 6'd59;
    tick();
    chk("row2_col59", 32'(u_if.rd_char), 32'h3C);
    u_if.rd_col = 6'd60;
    tick();
    chk("row2_col60", 32'(u_if.rd_char), 32'h00);

    fetch(6'd0, -1, 8'h00, 1'b0, n_ceb, done_i, adb_ok, rd_ok, ovr_ok);
    chk("row0_done_at", 32'(done_i), 63);
    u_if.swap = 1'b1;
    tick();
    u_if.swap   = 1'b0;
    u_if.rd_col = 6'd5;
    tick();
    chk("row0_col5", 32'(u_if.rd_char), 32'h45);
    fetch(6'd1, -1, 8'h45, 1'b1, n_ceb, done_i, adb_ok, rd_ok, ovr_ok);
    chk("pingpong_front", 32'(rd_ok), 1);
    chk("row1_adb_seq", 32'(adb_ok), 1);
    tick();
    chk("pingpong_hold", 32'(u_if.rd_char), 32'h45);
    u_if.swap = 1'b1;
    tick();
    u_if.swap = 1'b0;
    tick();
    chk("row1_col5", 32'(u_if.rd_char), 32'h85);

    chk("ovr_pre", 32'(u_if.overrun), 0);
    fetch(6'd2, 10, 8'h00, 1'b0, n_ceb, done_i, adb_ok, rd_ok, ovr_ok);
    chk("ovr_timing", 32'(ovr_ok), 1);
    chk("ovr_ceb_len", 32'(n_ceb), 60);
    chk("ovr_done_at", 32'(done_i), 63);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (u_if.ceb) cnt++;
    end
    chk("ovr_no_second", 32'(cnt), 0);

    fetch(6'd34, -1, 8'h00, 1'b0, n_ceb, done_i, adb_ok, rd_ok, ovr_ok);
    chk("oor_ceb", 32'(n_ceb), 0);
    chk("oor_done_at", 32'(done_i), 63);
    u_if.swap = 1'b1;
    tick();
    u_if.swap = 1'b0;
    cnt = 0;
    for (int c = 0; c < 64; c++) begin
      u_if.rd_col = 6'(c);
      tick();
      if (u_if.rd_char !== 8'h00) cnt++;
    end
    chk("oor_blank", 32'(cnt), 0);
    chk("ovr_sticky", 32'(u_if.overrun), 1);

    u_if2.text_row = 6'd0;
    u_if2.line_req = 1'b1;
    tick();
    u_if2.line_req = 1'b0;
    n_ceb  = 0;
    done_i = -1;
    adb_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (u_if2.ceb) begin
        exp_adb = 13'(32'h1FF0 + n_ceb);
        if (u_if2.adb !== exp_adb) adb_ok = 1'b0;
        n_ceb++;
      end
      if (u_if2.line_done) begin
        done_i = i;
        break;
      end
      tick();
    end
    chk("wrap_adb_seq", 32'(adb_ok), 1);
    chk("wrap_ceb_len", 32'(n_ceb), 60);
    chk("wrap_done_at", 32'(done_i), 63);
    u_if2.swap = 1'b1;
    tick();
    u_if2.swap   = 1'b0;
    u_if2.rd_col = 6'd15;
    tick();
    chk("wrap_col15", 32'(u_if2.rd_char), 32'hAF);
    u_if2.rd_col = 6'd20;
    tick();
    chk("wrap_col20", 32'(u_if2.rd_char), 32'hB4);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovr_cleared", 32'(u_if.overrun), 0);

    u_if.text_row = 6'd2;
    u_if.line_req = 1'b1;
    tick();
    u_if.line_req = 1'b0;
    repeat (19) tick();
    chk("abort_ceb20", 32'(u_if.ceb), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(u_if.busy), 0);
    chk("abort_ceb", 32'(u_if.ceb), 0);
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (u_if.line_done || u_if.ceb || u_if.busy) cnt++;
      tick();
    end
    chk("abort_quiet", 32'(cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_line_fetch.md
Name: vram_line_fetch

Overview:
- Read-side companion to the text VRAM write path. Handles the other end of the Gowin SDPB text VRAM (write port A = CPU/init, read port B = display).
- On request, streams one text row of character codes out of BSRAM port B into a ping-pong line buffer.
- The LCD glyph renderer indexes the front buffer by column while the next row fetches into the back buffer.

Parameters:
- COLS, 60: characters per text row (480 px / 8 px glyph).
- ROWS, 34: text rows (272 px / 8 px glyph).
- ADDR_W, 13: BSRAM address width (8 KB x 8).
- VRAM_BASE, 13'h0200: byte address of row 0, column 0.
- READ_LATENCY, 2: cycles from ceb/adb sampled to dout valid (SDPB with output register, oce high).

Ports:
- clk  in  1  system clock, shared with the BSRAM clkb.
- rst  in  1  synchronous reset, active-high.
- line_req  in  1  single-cycle pulse: fetch row text_row into the back buffer.
- text_row  in  6  row index, sampled with line_req.
- swap  in  1  single-cycle pulse: exchange front and back buffers.
- rd_col  in  6  column index into the front buffer.
- rd_char  out  8  character code at front[rd_col], registered.
- busy  out  1  fetch in progress.
- line_done  out  1  single-cycle pulse: back buffer complete.
- overrun  out  1  sticky: line_req arrived while busy.
- ceb  out  1  BSRAM port-B read enable.
- oce  out  1  BSRAM output-register clock enable.
- adb  out  ADDR_W  BSRAM port-B read address.
- dout  in  8  BSRAM port-B read data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: busy, line_done, overrun, ceb and adb are 0. oce is 0. rd_char is 8'h00. Front select is 0 (buffer A is front). Issue and capture counters are cleared and the valid pipe is emptied.
- Buffer RAM is not cleared by reset; its contents are unspecified until the first fetch.
- Reset mid-fetch aborts the fetch immediately. No line_done is issued.
- FSM states: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
  - IDLE: line_req sampled high latches text_row and latches the target buffer (current back buffer), then goes to ISSUE.
  - ISSUE: ceb=1 for exactly COLS consecutive cycles.
    - adb = (VRAM_BASE + text_row*COLS + issue_col) mod 2^ADDR_W, with issue_col running 0..COLS-1.
    - The column index enters a valid/column shift pipe of depth READ_LATENCY.
  - DRAIN: ceb=0. Wait until the pipe is empty.
    - Each pipe output writes dout to target[col].
  - DONE: line_done=1 for one cycle, then IDLE.
- Timing: if line_req is sampled at edge E0:
  - ceb is high in cycles E1..E(COLS).
  - The last buffer write happens at E(COLS+READ_LATENCY).
  - line_done is high in the cycle after E(COLS+READ_LATENCY+1); with defaults, 63 cycles after the request.
- busy: high from the cycle after line_req is sampled through the line_done cycle, inclusive.
- oce = busy.
- Out-of-range row (text_row >= ROWS): ceb stays 0 and no reads are issued. The target buffer is filled with 8'h00 on identical timing, and line_done still fires.
- line_req while busy: ignored, the current fetch is unaffected, and overrun is set to 1. overrun clears only on rst.
- line_req in the same cycle as line_done: ignored, counts as busy, and sets overrun.
- swap: toggles the front select on the next edge.
  - Allowed at any time.
  - An in-flight fetch keeps writing to the buffer latched at its line_req, even if that buffer has become the front.
  - swap coincident with line_done is legal; the completed buffer becomes front.
- rd_char: front[rd_col] one cycle after rd_col is presented (1-cycle latency). If rd_col >= COLS, rd_char = 8'h00.
- Address arithmetic: done at ADDR_W+6 bits, then truncated, so wrap past 13'h1FFF returns to 0.

Test Plan:
- Reset then idle: assert rst for 3 cycles. busy, line_done, overrun, ceb, adb, oce and rd_char are all 0; no ceb activity for 100 cycles.
- Row fetch: preload the BSRAM model with VRAM[0x0200+60*2+k]=k+1, pulse line_req with text_row=2, then pulse swap after line_done.
  - adb runs 0x0278..0x02B3 with ceb high exactly 60 cycles.
  - line_done comes exactly 63 cycles after the request.
  - rd_col=5 gives rd_char=8'h06 one cycle later; rd_col=60 gives 8'h00.
- Ping-pong isolation: fetch row 0 and swap, then fetch row 1 without swap. rd_char still shows row-0 data throughout the second fetch.
- Overrun: pulse line_req at +0 and +10 cycles. Only one 60-cycle ceb burst occurs, overrun=1 from cycle +11, and it stays 1 until rst.
- Out-of-range: text_row=34 produces no ceb, line_done at +63, and after swap every rd_char is 8'h00.
- Wrap and abort:
  - With VRAM_BASE=13'h1FF0 and text_row=0, adb goes 0x1FF0..0x1FFF, then 0x0000..0x002B.
  - Asserting rst at ceb cycle 20 gives busy=0 next cycle and no line_done.
